mips_cpu_muldiv_unit: RTL and testbench



---
 rtl/mips_cpu_muldiv_unit_if.sv | 25 ++
 rtl/mips_cpu_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_mips_cpu_muldiv_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_unit_if.sv
// Request/result bundle between the MIPS core and its multiply/divide unit.
// The core drives the op_* request fields and reads back busy/done and the HI/LO pair.
interface mips_cpu_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, op_a, op_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO complete in one cycle.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle array multiply.
module mips_cpu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  mips_cpu_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     is_div, neg_res, neg_rem, dbz;
  logic                     done_r, dbz_r;
  logic [WIDTH-1:0]         hi_r, lo_r;
  logic [WIDTH-1:0]         opnd, opnd_nxt;
  logic [W2-1:0]            acc, acc_nxt;
  logic                     accept, start, op_signed;
  logic signed [WIDTH-1:0]  a_s, b_s;
  logic [WIDTH-1:0]         a_mag, b_mag;
  logic [W2-1:0]            prod_fix;
  logic [WIDTH-1:0]         quo_fix, rem_fix;

  // Most-negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] apply_sign_2w(input logic [W2-1:0] v, input logic neg);
    return neg ? ((~v) + W2'(1)) : v;
  endfunction

`ifndef MULDIV_FAST_MUL_EN
  // acc = {partial product, unconsumed multiplier bits}; one multiplier bit retired per call.
  function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] a, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = {1'b0, a[W2-1:WIDTH]} + (a[0] ? {1'b0, m} : '0);
    return {sum, a[WIDTH-1:1]};
  endfunction
`endif

  // acc = {remainder, dividend/quotient}; the remainder stays below the divisor so WIDTH bits suffice.
  function automatic logic [W2-1:0] div_step(input logic [W2-1:0] a, input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    shifted = a[W2-1:WIDTH-1];
    ge      = (shifted >= {1'b0, d});
    diff    = shifted[WIDTH-1:0] - d;
    return ge ? {diff, a[WIDTH-2:0], 1'b1} : {shifted[WIDTH-1:0], a[WIDTH-2:0], 1'b0};
  endfunction

  assign a_s       = $signed(bus.op_a);
  assign b_s       = $signed(bus.op_b);
  assign op_signed = !bus.op_code[0];
  assign a_mag     = op_signed ? abs_mag(a_s) : bus.op_a;
  assign b_mag     = op_signed ? abs_mag(b_s) : bus.op_b;
  assign accept    = bus.op_valid && (state == S_IDLE) && (bus.op_code <= OP_MTLO);
  assign start     = accept && !bus.op_code[2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    opnd_nxt  = opnd;
    acc_nxt   = acc;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_nxt = CNT_W'(WIDTH - 1);
          if (bus.op_code[1]) begin
            state_nxt = S_DIV;
            opnd_nxt  = b_mag;
            acc_nxt   = {{WIDTH{1'b0}}, a_mag};
          end else begin
            state_nxt = S_MUL;
            opnd_nxt  = a_mag;
            acc_nxt   = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        acc_nxt   = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
        state_nxt = S_FIX;
`else
        acc_nxt = mul_step(acc, opnd);
        if (cnt == '0) state_nxt = S_FIX;
        else           cnt_nxt   = cnt - CNT_W'(1);
`endif
      end
      S_DIV: begin
        acc_nxt = div_step(acc, opnd);
        if (cnt == '0) state_nxt = S_FIX;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sign fix-up; a zero divisor leaves the dividend magnitude as remainder, so only LO needs overriding.
  always_comb begin
    prod_fix = apply_sign_2w(acc, neg_res);
    quo_fix  = dbz ? '1 : apply_sign_w(acc[WIDTH-1:0], neg_res);
    rem_fix  = apply_sign_w(acc[W2-1:WIDTH], neg_rem);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz     <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (clk_enable) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_r <= (state == S_FIX);
      dbz_r  <= (state == S_FIX) && dbz;
      if (start) begin
        is_div  <= bus.op_code[1];
        neg_res <= op_signed && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
        neg_rem <= op_signed && a_s[WIDTH-1];
        dbz     <= bus.op_code[1] && (bus.op_b == '0);
      end
      if (accept && (bus.op_code == OP_MTHI)) hi_r <= bus.op_a;
      if (accept && (bus.op_code == OP_MTLO)) lo_r <= bus.op_a;
      if (state == S_FIX) begin
        if (is_div) begin
          hi_r <= rem_fix;
          lo_r <= quo_fix;
        end else begin
          {hi_r, lo_r} <= prod_fix;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_enable) begin
      opnd <= opnd_nxt;
      acc  <= acc_nxt;
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Bench for mips_cpu_muldiv_unit: a 32-bit and an 8-bit instance checked against an arithmetic HI/LO model.
module tb_mips_cpu_muldiv_unit;

  localparam int W  = 32;
  localparam int W8 = 8;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 2;
  localparam int MUL_LAT8 = 2;
`else
  localparam int MUL_LAT  = W + 1;
  localparam int MUL_LAT8 = W8 + 1;
`endif
  localparam int DIV_LAT  = W + 1;
  localparam int DIV_LAT8 = W8 + 1;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic clk_enable = 1'b1;

  int total = 0;
  int bad   = 0;

  longint unsigned m_hi  = 0, m_lo  = 0;
  longint unsigned m8_hi = 0, m8_lo = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv_unit_if #(.WIDTH(W))  bus32 ();
  mips_cpu_muldiv_unit_if #(.WIDTH(W8)) bus8 ();

  mips_cpu_muldiv_unit #(.WIDTH(W)) dut32 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .bus        (bus32.slave)
  );

  mips_cpu_muldiv_unit #(.WIDTH(W8)) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .bus        (bus8.slave)
  );

  // HI/LO behaviour from the instruction definitions using 64-bit arithmetic.
  function automatic void ref_op(input int w, input logic [2:0] op,
                                 input longint unsigned a, input longint unsigned b,
                                 inout longint unsigned hi, inout longint unsigned lo,
                                 output bit dz);
    longint unsigned mask, up;
    longint          sa, sb, sp;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed(a);
    sb = $signed(b);
    if (((a >> (w - 1)) & 64'd1) != 0) sa = sa - $signed(64'd1 << w);
    if (((b >> (w - 1)) & 64'd1) != 0) sb = sb - $signed(64'd1 << w);
    dz = 1'b0;
    case (op)
      3'd0: begin sp = sa * sb; up = sp; hi = (up >> w) & mask; lo = up & mask; end
      3'd1: begin up = a * b; hi = (up >> w) & mask; lo = up & mask; end
      3'd2: begin
        if (b == 0) begin hi = a; lo = mask; dz = 1'b1; end
        else begin up = sa % sb; hi = up & mask; up = sa / sb; lo = up & mask; end
      end
      3'd3: begin
        if (b == 0) begin hi = a; lo = mask; dz = 1'b1; end
        else begin hi = (a % b) & mask; lo = (a / b) & mask; end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input bit w8);
    if (op <= 3'd1) return w8 ? MUL_LAT8 : MUL_LAT;
    if (op <= 3'd3) return w8 ? DIV_LAT8 : DIV_LAT;
    return 0;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] pick8();
    case ($urandom_range(0, 5))
      0: return 32'h00;
      1: return 32'h01;
      2: return 32'h80;
      3: return 32'hFF;
      4: return 32'h7F;
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic do_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc, output bit early, output bit tmo);
    if (w8) begin
      bus8.op_valid = 1'b1; bus8.op_code = op; bus8.op_a = a[7:0]; bus8.op_b = b[7:0];
    end else begin
      bus32.op_valid = 1'b1; bus32.op_code = op; bus32.op_a = a; bus32.op_b = b;
    end
    @(posedge clk);
    #1;
    bus8.op_valid  = 1'b0;
    bus32.op_valid = 1'b0;
    cyc = 0; early = 1'b0; tmo = 1'b0;
    @(negedge clk);
    while ((w8 ? bus8.busy : bus32.busy) && !tmo) begin
      cyc++;
      if (w8 ? bus8.done : bus32.done) early = 1'b1;
      if (cyc > 300) tmo = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus32.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus32.busy); end
    total++; if (bus32.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus32.done); end
    total++; if (bus32.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", bus32.div_by_zero); end
    total++; if (bus32.hi !== 32'h0 || bus32.lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h:%h want=0:0", bus32.hi, bus32.lo); end
    total++; if (bus8.hi !== 8'h0 || bus8.lo !== 8'h0 || bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_w8 got=%h:%h busy=%b want=0:0 busy=0", bus8.hi, bus8.lo, bus8.busy); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_vectors();
    logic [2:0]  ov [5];
    logic [31:0] av [5];
    logic [31:0] bv [5];
    int cyc; bit early, tmo, edz;
    ov = '{3'd0, 3'd3, 3'd2, 3'd2, 3'd2};
    av = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9};
    bv = '{32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 5; i++) begin
      ref_op(W, ov[i], 64'(av[i]), 64'(bv[i]), m_hi, m_lo, edz);
      do_op(1'b0, ov[i], av[i], bv[i], cyc, early, tmo);
      total++; if (tmo || early || cyc != lat_of(ov[i], 1'b0)) begin bad++; $display("FAIL plan_timing[%0d] busy_cycles=%0d early_done=%b timeout=%b want=%0d", i, cyc, early, tmo, lat_of(ov[i], 1'b0)); end
      total++; if (bus32.hi !== m_hi[31:0] || bus32.lo !== m_lo[31:0]) begin bad++; $display("FAIL plan_result[%0d] got=%h:%h want=%h:%h", i, bus32.hi, bus32.lo, m_hi[31:0], m_lo[31:0]); end
      total++; if (bus32.done !== 1'b1 || bus32.div_by_zero !== edz) begin bad++; $display("FAIL plan_flags[%0d] done=%b dbz=%b want done=1 dbz=%b", i, bus32.done, bus32.div_by_zero, edz); end
    end
  endtask

  task automatic test_mt();
    int cyc; bit early, tmo, edz;
    ref_op(W, 3'd5, 64'h1234, 64'd0, m_hi, m_lo, edz);
    do_op(1'b0, 3'd5, 32'h1234, 32'd0, cyc, early, tmo);
    total++; if (cyc != 0 || tmo || bus32.done !== 1'b0) begin bad++; $display("FAIL mtlo_busy busy_cycles=%0d done=%b want=0 0", cyc, bus32.done); end
    total++; if (bus32.lo !== 32'h1234 || bus32.hi !== m_hi[31:0]) begin bad++; $display("FAIL mtlo_value got=%h:%h want=%h:00001234", bus32.hi, bus32.lo, m_hi[31:0]); end
    ref_op(W, 3'd4, 64'hCAFE_F00D, 64'd0, m_hi, m_lo, edz);
    do_op(1'b0, 3'd4, 32'hCAFE_F00D, 32'd0, cyc, early, tmo);
    total++; if (cyc != 0 || bus32.hi !== m_hi[31:0] || bus32.lo !== m_lo[31:0]) begin bad++; $display("FAIL mthi_value got=%h:%h busy_cycles=%0d want=%h:%h 0", bus32.hi, bus32.lo, cyc, m_hi[31:0], m_lo[31:0]); end
  endtask

  task automatic test_mt_while_busy();
    int cyc; bit tmo, edz;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    ref_op(W, 3'd0, 64'(a), 64'(b), m_hi, m_lo, edz);
    bus32.op_valid = 1'b1; bus32.op_code = 3'd0; bus32.op_a = a; bus32.op_b = b;
    @(posedge clk);
    #1;
    bus32.op_code = 3'd4; bus32.op_a = 32'hDEAD_BEEF;
    cyc = 0; tmo = 1'b0;
    @(negedge clk);
    while (bus32.busy && !tmo) begin
      cyc++;
      if (cyc > 300) tmo = 1'b1;
      else @(negedge clk);
    end
    bus32.op_valid = 1'b0;
    total++; if (tmo || cyc != MUL_LAT) begin bad++; $display("FAIL mthi_busy_timing busy_cycles=%0d want=%0d", cyc, MUL_LAT); end
    total++; if (bus32.hi !== m_hi[31:0] || bus32.lo !== m_lo[31:0] || bus32.done !== 1'b1) begin bad++; $display("FAIL mthi_busy_result got=%h:%h done=%b want=%h:%h done=1", bus32.hi, bus32.lo, bus32.done, m_hi[31:0], m_lo[31:0]); end
    @(negedge clk);
    total++; if (bus32.done !== 1'b0 || bus32.hi !== m_hi[31:0]) begin bad++; $display("FAIL done_clear done=%b hi=%h want done=0 hi=%h", bus32.done, bus32.hi, m_hi[31:0]); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit early, tmo, edz;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom() | 32'h100;
    ref_op(W, 3'd2, 64'(a), 64'(b), m_hi, m_lo, edz);
    do_op(1'b0, 3'd2, a, b, cyc, early, tmo);
    total++; if (tmo || cyc != DIV_LAT || bus32.lo !== m_lo[31:0] || bus32.hi !== m_hi[31:0]) begin bad++; $display("FAIL b2b_first got=%h:%h cycles=%0d want=%h:%h %0d", bus32.hi, bus32.lo, cyc, m_hi[31:0], m_lo[31:0], DIV_LAT); end
    a = $urandom(); b = $urandom();
    ref_op(W, 3'd1, 64'(a), 64'(b), m_hi, m_lo, edz);
    do_op(1'b0, 3'd1, a, b, cyc, early, tmo);
    total++; if (tmo || early || cyc != MUL_LAT) begin bad++; $display("FAIL b2b_second_timing cycles=%0d early_done=%b want=%0d 0", cyc, early, MUL_LAT); end
    total++; if (bus32.hi !== m_hi[31:0] || bus32.lo !== m_lo[31:0] || bus32.done !== 1'b1) begin bad++; $display("FAIL b2b_second_result got=%h:%h done=%b want=%h:%h", bus32.hi, bus32.lo, bus32.done, m_hi[31:0], m_lo[31:0]); end
    ref_op(W, 3'd5, 64'h5A5A_0001, 64'd0, m_hi, m_lo, edz);
    do_op(1'b0, 3'd5, 32'h5A5A_0001, 32'd0, cyc, early, tmo);
    total++; if (bus32.lo !== m_lo[31:0] || bus32.done !== 1'b0 || cyc != 0) begin bad++; $display("FAIL b2b_mtlo lo=%h done=%b want=%h done=0", bus32.lo, bus32.done, m_lo[31:0]); end
  endtask

  task automatic test_random();
    int cyc; bit early, tmo, edz;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick32(); b = pick32();
      ref_op(W, op, 64'(a), 64'(b), m_hi, m_lo, edz);
      do_op(1'b0, op, a, b, cyc, early, tmo);
      total++; if (tmo || early || cyc != lat_of(op, 1'b0)) begin bad++; $display("FAIL rand_timing[%0d] op=%0d cycles=%0d early=%b timeout=%b want=%0d", i, op, cyc, early, tmo, lat_of(op, 1'b0)); end
      total++; if (bus32.hi !== m_hi[31:0] || bus32.lo !== m_lo[31:0]) begin bad++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h:%h want=%h:%h", i, op, a, b, bus32.hi, bus32.lo, m_hi[31:0], m_lo[31:0]); end
      total++; if (bus32.done !== logic'(op <= 3'd3) || bus32.div_by_zero !== edz) begin bad++; $display("FAIL rand_flags[%0d] op=%0d done=%b dbz=%b want done=%b dbz=%b", i, op, bus32.done, bus32.div_by_zero, op <= 3'd3, edz); end
    end
  endtask

  task automatic test_clk_enable();
    int en_cnt, guard; bit tmo, held_ok, edz;
    longint unsigned old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    ref_op(W, 3'd3, 64'hFFFF_FFFF, 64'd3, m_hi, m_lo, edz);
    bus32.op_valid = 1'b1; bus32.op_code = 3'd3; bus32.op_a = 32'hFFFF_FFFF; bus32.op_b = 32'd3;
    @(posedge clk);
    #1;
    bus32.op_valid = 1'b0;
    en_cnt = 0; guard = 0; tmo = 1'b0; held_ok = 1'b1;
    @(negedge clk);
    while (bus32.busy && !tmo) begin
      if (bus32.hi !== old_hi[31:0] || bus32.lo !== old_lo[31:0] || bus32.done !== 1'b0) held_ok = 1'b0;
      clk_enable = ($urandom_range(0, 2) != 0);
      if (clk_enable) en_cnt++;
      guard++;
      if (guard > 2000) tmo = 1'b1;
      else @(negedge clk);
    end
    clk_enable = 1'b1;
    total++; if (tmo || en_cnt != DIV_LAT) begin bad++; $display("FAIL cen_latency enabled_cycles=%0d want=%0d", en_cnt, DIV_LAT); end
    total++; if (!held_ok) begin bad++; $display("FAIL cen_hold hi/lo/done changed while busy, want %h:%h", old_hi[31:0], old_lo[31:0]); end
    total++; if (bus32.hi !== m_hi[31:0] || bus32.lo !== m_lo[31:0] || bus32.done !== 1'b1) begin bad++; $display("FAIL cen_result got=%h:%h done=%b want=%h:%h done=1", bus32.hi, bus32.lo, bus32.done, m_hi[31:0], m_lo[31:0]); end
    clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus32.done !== 1'b1 || bus32.busy !== 1'b0) begin bad++; $display("FAIL cen_done_hold done=%b busy=%b want 1 0", bus32.done, bus32.busy); end
    clk_enable = 1'b1;
    @(negedge clk);
    total++; if (bus32.done !== 1'b0) begin bad++; $display("FAIL cen_done_clear done=%b want=0", bus32.done); end
  endtask

  task automatic test_width8();
    int cyc; bit early, tmo, edz;
    logic [2:0]  op;
    logic [31:0] a, b;
    ref_op(W8, 3'd1, 64'hFF, 64'hFF, m8_hi, m8_lo, edz);
    do_op(1'b1, 3'd1, 32'hFF, 32'hFF, cyc, early, tmo);
    total++; if (tmo || cyc != MUL_LAT8) begin bad++; $display("FAIL w8_multu_timing cycles=%0d want=%0d", cyc, MUL_LAT8); end
    total++; if (bus8.hi !== m8_hi[7:0] || bus8.lo !== m8_lo[7:0] || bus8.done !== 1'b1) begin bad++; $display("FAIL w8_multu_result got=%h:%h want=%h:%h", bus8.hi, bus8.lo, m8_hi[7:0], m8_lo[7:0]); end
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick8(); b = pick8();
      ref_op(W8, op, 64'(a[7:0]), 64'(b[7:0]), m8_hi, m8_lo, edz);
      do_op(1'b1, op, a, b, cyc, early, tmo);
      total++; if (tmo || early || cyc != lat_of(op, 1'b1)) begin bad++; $display("FAIL w8_rand_timing[%0d] op=%0d cycles=%0d want=%0d", i, op, cyc, lat_of(op, 1'b1)); end
      total++; if (bus8.hi !== m8_hi[7:0] || bus8.lo !== m8_lo[7:0] || bus8.div_by_zero !== edz) begin bad++; $display("FAIL w8_rand_result[%0d] op=%0d a=%h b=%h got=%h:%h dbz=%b want=%h:%h dbz=%b", i, op, a[7:0], b[7:0], bus8.hi, bus8.lo, bus8.div_by_zero, m8_hi[7:0], m8_lo[7:0], edz); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus32.op_valid = 1'b1; bus32.op_code = 3'd3; bus32.op_a = $urandom(); bus32.op_b = $urandom() | 32'h1;
    @(posedge clk);
    #1;
    bus32.op_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (bus32.busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before got=%b want=1", bus32.busy); end
    #2;
    reset_n = 1'b0;
    #1;
    m_hi = 0; m_lo = 0; m8_hi = 0; m8_lo = 0;
    total++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl busy=%b done=%b want 0 0", bus32.busy, bus32.done); end
    total++; if (bus32.hi !== 32'h0 || bus32.lo !== 32'h0 || bus8.hi !== 8'h0 || bus8.lo !== 8'h0) begin bad++; $display("FAIL rst_mid_hilo got=%h:%h w8=%h:%h want zeros", bus32.hi, bus32.lo, bus8.hi, bus8.lo); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen || bus32.hi !== m_hi[31:0] || bus32.lo !== m_lo[31:0]) begin bad++; $display("FAIL rst_mid_after done/busy_seen=%b hi:lo=%h:%h want 0 and zeros", seen, bus32.hi, bus32.lo); end
  endtask

  initial begin
    bus32.op_valid = 1'b0; bus32.op_code = 3'd0; bus32.op_a = '0; bus32.op_b = '0;
    bus8.op_valid  = 1'b0; bus8.op_code  = 3'd0; bus8.op_a  = '0; bus8.op_b  = '0;
    test_reset();
    test_plan_vectors();
    test_mt();
    test_mt_while_busy();
    test_back_to_back();
    test_random();
    test_clk_enable();
    test_width8();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
